// File: rtl/countdown_timer_mmss.sv
// countdown_timer_mmss: counts a loaded BCD MM:SS value down to 00:00 on a synchronized slow tick.
// Optional macro DONE_LATCH_EN: done holds high in DONE until the next load/reset (default: 1-cycle pulse).
module countdown_timer_mmss #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned MAX_MIN_TENS = 9
) (
    input  logic        in_clock,
    input  logic        reset,
    input  logic        tick_in,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        start,
    input  logic        pause,
    output logic [15:0] time_bcd,
    output logic        running,
    output logic        done
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOADED  = 3'd1;
    localparam logic [2:0] ST_RUNNING = 3'd2;
    localparam logic [2:0] ST_PAUSED  = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam logic [3:0] MT_MAX = 4'(MAX_MIN_TENS);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   tick_prev;
    logic                   tick_pulse;
    logic [2:0]             state, state_n;
    logic [15:0]            time_q, time_n;
    logic                   done_q, done_n;
    logic                   enter_done;

    function automatic logic [15:0] clamp_bcd(input logic [15:0] v);
        logic [3:0] mt, mu, st, su;
        {mt, mu, st, su} = v;
        if (mt > 4'd9) mt = 4'd9;
        if (mu > 4'd9) mu = 4'd9;
        if (st > 4'd9) st = 4'd9;
        if (su > 4'd9) su = 4'd9;
        if (st > 4'd5) st = 4'd5;
        if (mt > MT_MAX) mt = MT_MAX;
        return {mt, mu, st, su};
    endfunction

    // Caller guarantees t != 0, so the minutes-tens borrow never underflows.
    function automatic logic [15:0] dec_bcd(input logic [15:0] t);
        logic [3:0] mt, mu, st, su;
        {mt, mu, st, su} = t;
        if (su != 4'd0) begin
            su = su - 4'd1;
        end else begin
            su = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mu != 4'd0) begin
                    mu = mu - 4'd1;
                end else begin
                    mu = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mu, st, su};
    endfunction

    assign tick_pulse = sync_q[SYNC_STAGES-1] & ~tick_prev;

    always_comb begin
        state_n    = state;
        time_n     = time_q;
        enter_done = 1'b0;
        if (load) begin
            state_n = ST_LOADED;
            time_n  = clamp_bcd(load_value);
        end else begin
            case (state)
                ST_LOADED: begin
                    if (start && !pause && time_q != '0) state_n = ST_RUNNING;
                end
                ST_RUNNING: begin
                    if (pause) begin
                        state_n = ST_PAUSED;
                    end else if (tick_pulse && time_q != '0) begin
                        time_n = dec_bcd(time_q);
                        if (time_n == '0) begin
                            state_n    = ST_DONE;
                            enter_done = 1'b1;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (start && !pause) state_n = ST_RUNNING;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
`ifdef DONE_LATCH_EN
        done_n = load ? 1'b0 : (done_q | enter_done);
`else
        done_n = enter_done;
`endif
    end

    always_ff @(posedge in_clock or posedge reset) begin
        if (reset) begin
            sync_q    <= '0;
            tick_prev <= 1'b0;
            state     <= ST_IDLE;
            time_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], tick_in};
            tick_prev <= sync_q[SYNC_STAGES-1];
            state     <= state_n;
            time_q    <= time_n;
            done_q    <= done_n;
        end
    end

    assign time_bcd = time_q;
    assign running  = (state == ST_RUNNING);
    assign done     = done_q;

endmodule

// File: tb/tb_countdown_timer_mmss.sv
// tb_countdown_timer_mmss: directed and randomized checks of countdown_timer_mmss
// against a seconds-count reference model.
module tb_countdown_timer_mmss;

    localparam int unsigned SYNC  = 2;
    localparam int          MAXMT = 9;

    localparam int M_IDLE = 0, M_LOADED = 1, M_RUN = 2, M_PAUSED = 3, M_DONE = 4;

    logic        in_clock = 1'b0;
    logic        reset, tick_in, load, start, pause;
    logic [15:0] load_value;
    logic [15:0] time_bcd;
    logic        running, done;

    int vectors = 0;
    int miscompares = 0;

    int m_secs;
    int m_mode;
    bit m_done;

    countdown_timer_mmss #(.SYNC_STAGES(SYNC), .MAX_MIN_TENS(MAXMT)) dut (
        .in_clock  (in_clock),
        .reset     (reset),
        .tick_in   (tick_in),
        .load      (load),
        .load_value(load_value),
        .start     (start),
        .pause     (pause),
        .time_bcd  (time_bcd),
        .running   (running),
        .done      (done)
    );

    always #5 in_clock = ~in_clock;

    function automatic int bcd_to_secs(input logic [15:0] v);
        int d3, d2, d1, d0;
        d3 = int'(v[15:12]); d2 = int'(v[11:8]); d1 = int'(v[7:4]); d0 = int'(v[3:0]);
        if (d3 > 9) d3 = 9;
        if (d2 > 9) d2 = 9;
        if (d1 > 9) d1 = 9;
        if (d0 > 9) d0 = 9;
        if (d1 > 5) d1 = 5;
        if (d3 > MAXMT) d3 = MAXMT;
        return (d3 * 10 + d2) * 60 + d1 * 10 + d0;
    endfunction

    function automatic logic [15:0] secs_to_bcd(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic model_reset();
        m_secs = 0;
        m_mode = M_IDLE;
        m_done = 1'b0;
    endtask

    task automatic model_step(input bit ld, input bit st, input bit pa, input bit tk,
                              input logic [15:0] val);
`ifndef DONE_LATCH_EN
        m_done = 1'b0;
`endif
        if (ld) begin
            m_secs = bcd_to_secs(val);
            m_mode = M_LOADED;
            m_done = 1'b0;
        end else begin
            case (m_mode)
                M_LOADED: if (st && !pa && m_secs != 0) m_mode = M_RUN;
                M_RUN: begin
                    if (pa) m_mode = M_PAUSED;
                    else if (tk && m_secs > 0) begin
                        m_secs = m_secs - 1;
                        if (m_secs == 0) begin
                            m_mode = M_DONE;
                            m_done = 1'b1;
                        end
                    end
                end
                M_PAUSED: if (st && !pa) m_mode = M_RUN;
                default: ;
            endcase
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".time"}, time_bcd, secs_to_bcd(m_secs));
        check({tag, ".running"}, {15'b0, running}, {15'b0, (m_mode == M_RUN)});
        check({tag, ".done"}, {15'b0, done}, {15'b0, m_done});
    endtask

    task automatic cycle(input string tag, input bit ld, input bit st, input bit pa,
                         input bit tk, input logic [15:0] val);
        load = ld; start = st; pause = pa; load_value = val;
        @(posedge in_clock);
        #1;
        load = 1'b0; start = 1'b0; pause = 1'b0;
        model_step(ld, st, pa, tk, val);
        check_all(tag);
    endtask

    // act: 0 plain tick, 1 pause on the pulse cycle, 2 load val on the pulse cycle
    task automatic tick_once(input string tag, input int act, input logic [15:0] val);
        tick_in = 1'b1;
        for (int i = 0; i < int'(SYNC); i++) cycle({tag, ".sync"}, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        cycle({tag, ".edge"}, act == 2, 1'b0, act == 1, 1'b1, val);
        tick_in = 1'b0;
        for (int i = 0; i <= int'(SYNC); i++) cycle({tag, ".settle"}, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    initial begin
        logic [15:0] rv;
        int nsteps, r;

        reset = 1'b1; tick_in = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; load_value = '0;
        repeat (2) @(posedge in_clock);
        #1 reset = 1'b0;
        model_reset();
        check_all("reset");

        cycle("idle_start", 0, 1, 0, 0, 16'h0);

        cycle("ld0102", 1, 0, 0, 0, 16'h0102);
        cycle("st0102", 0, 1, 0, 0, 16'h0);
        tick_once("t0101", 0, 16'h0);
        tick_once("t0100", 0, 16'h0);

        cycle("ld0100", 1, 0, 0, 0, 16'h0100);
        cycle("st0100", 0, 1, 0, 0, 16'h0);
        tick_once("t0059", 0, 16'h0);
        cycle("ld1000", 1, 0, 0, 0, 16'h1000);
        cycle("st1000", 0, 1, 0, 0, 16'h0);
        tick_once("t0959", 0, 16'h0);

        cycle("ld0001", 1, 0, 0, 0, 16'h0001);
        cycle("st0001", 0, 1, 0, 0, 16'h0);
        tick_once("tdone", 0, 16'h0);
        tick_once("tnowrap", 0, 16'h0);
        cycle("done_start", 0, 1, 0, 0, 16'h0);

        cycle("clamp", 1, 0, 0, 0, 16'hFA7C);
        cycle("ld0000", 1, 0, 0, 0, 16'h0000);
        cycle("st0000", 0, 1, 0, 0, 16'h0);
        tick_once("t0000", 0, 16'h0);

        cycle("ld0030", 1, 0, 0, 0, 16'h0030);
        cycle("st0030", 0, 1, 0, 0, 16'h0);
        cycle("pause", 0, 0, 1, 0, 16'h0);
        for (int i = 0; i < 3; i++) tick_once("tpaused", 0, 16'h0);
        cycle("resume", 0, 1, 0, 0, 16'h0);
        tick_once("t0029", 0, 16'h0);
        tick_once("tick_pause", 1, 16'h0);
        cycle("resume2", 0, 1, 0, 0, 16'h0);
        cycle("st_pa_both", 0, 1, 1, 0, 16'h0);
        cycle("resume3", 0, 1, 0, 0, 16'h0);
        tick_once("tick_load", 2, 16'h0045);

        cycle("ld0327", 1, 0, 0, 0, 16'h0327);
        cycle("st0327", 0, 1, 0, 0, 16'h0);
        #2 reset = 1'b1;
        #1 model_reset();
        check_all("async_reset");
        @(posedge in_clock);
        #1 reset = 1'b0;
        check_all("post_reset");

        for (int k = 0; k < 25; k++) begin
            rv = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 3));
            cycle("rnd_ld", 1, 0, 0, 0, rv);
            cycle("rnd_st", 0, 1, 0, 0, 16'h0);
            nsteps = int'($urandom_range(1, 6));
            for (int j = 0; j < nsteps; j++) begin
                r = int'($urandom_range(0, 5));
                case (r)
                    0: tick_once("rnd_tpa", 1, 16'h0);
                    1: cycle("rnd_pa", 0, 0, 1, 0, 16'h0);
                    2: cycle("rnd_st2", 0, 1, 0, 0, 16'h0);
                    3: cycle("rnd_both", 0, 1, 1, 0, 16'h0);
                    default: tick_once("rnd_t", 0, 16'h0);
                endcase
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
